// File: rtl/univ_shift_reg_pkg.sv
// Shared encodings for the universal shift register: operation modes,
// shift direction and the burst controller state type.
package univ_shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } burst_state_e;

  function automatic logic is_shift_mode(input logic [1:0] m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst controller: accepts a shift burst from IDLE, runs it for the captured
// count, then pulses done for one cycle before returning to IDLE.
module shift_burst_ctrl
  import univ_shift_reg_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             mode_en,
  output logic             shift_en,
  output logic             shift_dir,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  burst_state_e     state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             dir_r, dir_nxt_s;
  logic             busy_r, done_r, busy_nxt_s, done_nxt_s;
  logic             accept_s;

  // State, counter, direction and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      dir_r   <= DIR_RIGHT;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      dir_r   <= dir_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state and counter logic; counter saturates at its end so it never wraps
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    dir_nxt_s   = dir_r;
    accept_s    = (state_r == ST_IDLE) && start && is_shift_mode(mode) && (count != CNT_ZERO);
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = count;
          dir_nxt_s   = (mode == MODE_SHL) ? DIR_LEFT : DIR_RIGHT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r <= CNT_ONE) begin
          state_nxt_s = ST_DONE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Datapath controls from current state; flags pre-decoded from next state
  always_comb begin
    mode_en    = (state_r == ST_IDLE) && !accept_s;
    shift_en   = (state_r == ST_RUN);
    shift_dir  = dir_r;
    busy_nxt_s = (state_nxt_s == ST_RUN);
    done_nxt_s = (state_nxt_s == ST_DONE);
  end

  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with hold/shift/load modes and a counted
// burst-shift facility driven by shift_burst_ctrl.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       din_r,
  input  logic [WIDTH-1:0]       din_l,
  input  logic [WIDTH*DEPTH-1:0] pin,
  input  logic                   start,
  input  logic [CNT_W-1:0]       count,
  output logic [WIDTH*DEPTH-1:0] q,
  output logic [WIDTH-1:0]       sout_r,
  output logic [WIDTH-1:0]       sout_l,
  output logic                   busy,
  output logic                   done
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_r, stage_nxt_s;
  logic mode_en_s, shift_en_s, shift_dir_s;

  shift_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .start     (start),
    .count     (count),
    .mode_en   (mode_en_s),
    .shift_en  (shift_en_s),
    .shift_dir (shift_dir_s),
    .busy      (busy),
    .done      (done)
  );

  // Next stage contents: burst shifts override mode; mode applies only when idle
  always_comb begin
    stage_nxt_s = stage_r;
    if (shift_en_s) begin
      if (shift_dir_s == DIR_LEFT) begin
        stage_nxt_s = {din_l, stage_r[DEPTH-1:1]};
      end else begin
        stage_nxt_s = {stage_r[DEPTH-2:0], din_r};
      end
    end else if (mode_en_s) begin
      case (mode)
        MODE_HOLD: stage_nxt_s = stage_r;
        MODE_SHR:  stage_nxt_s = {stage_r[DEPTH-2:0], din_r};
        MODE_SHL:  stage_nxt_s = {din_l, stage_r[DEPTH-1:1]};
        MODE_LOAD: stage_nxt_s = pin;
        default:   stage_nxt_s = stage_r;
      endcase
    end else begin
      stage_nxt_s = stage_r;
    end
  end

  // Stage register
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_r <= '0;
    end else begin
      stage_r <= stage_nxt_s;
    end
  end

  assign q      = stage_r;
  assign sout_r = stage_r[DEPTH-1];
  assign sout_l = stage_r[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=1, DEPTH=4): directed scenarios
// followed by random traffic, checked against an arithmetic reference model.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       din_r, din_l;
  logic [3:0] pin;
  logic       start;
  logic [3:0] count;
  logic [3:0] q;
  logic       sout_r, sout_l, busy, done;

  typedef struct {
    logic [3:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // reference model: register as an integer, burst as remaining-shift count
  int m_q = 0;
  int m_state = 0;  // 0 idle, 1 bursting, 2 done cycle
  int m_rem = 0;
  int m_left = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(1), .DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .mode(mode), .din_r(din_r), .din_l(din_l),
    .pin(pin), .start(start), .count(count), .q(q), .sout_r(sout_r),
    .sout_l(sout_l), .busy(busy), .done(done)
  );

  function automatic int shr(input int v, input logic b);
    return ((v << 1) | int'(b)) & 15;
  endfunction

  function automatic int shl(input int v, input logic b);
    return (v >> 1) | (int'(b) << 3);
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] md, input logic dr, input logic dl,
                      input logic [3:0] p, input logic st, input logic [3:0] cnt);
    exp_t e;
    @(negedge clk);
    reset = rst; mode = md; din_r = dr; din_l = dl; pin = p; start = st; count = cnt;
    if (rst) begin
      m_q = 0; m_state = 0; m_rem = 0;
    end else if (m_state == 0) begin
      if (st && (md == 2'd1 || md == 2'd2) && cnt != 4'd0) begin
        m_state = 1; m_rem = int'(cnt); m_left = (md == 2'd2) ? 1 : 0;
      end else begin
        case (md)
          2'd1: m_q = shr(m_q, dr);
          2'd2: m_q = shl(m_q, dl);
          2'd3: m_q = int'(p);
          default: ;
        endcase
      end
    end else if (m_state == 1) begin
      m_q = (m_left != 0) ? shl(m_q, dl) : shr(m_q, dr);
      m_rem = m_rem - 1;
      if (m_rem == 0) m_state = 2;
    end else begin
      m_state = 0;
    end
    e.q = 4'(m_q);
    e.busy = (m_state == 1);
    e.done = (m_state == 2);
    @(posedge clk);
    sb_q.push_back(e);
  endtask

  // Monitor: compare every registered output presentation against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("q", q, e.q);
      chk("sout_r", {3'b000, sout_r}, {3'b000, e.q[3]});
      chk("sout_l", {3'b000, sout_l}, {3'b000, e.q[0]});
      chk("busy", {3'b000, busy}, {3'b000, e.busy});
      chk("done", {3'b000, done}, {3'b000, e.done});
    end
  end

  initial begin
    reset = 1'b1; mode = 2'b00; din_r = 1'b0; din_l = 1'b0;
    pin = 4'h0; start = 1'b0; count = 4'h0;

    // reset for two cycles
    step(1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    step(1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    // plain SHR with serial 1,0,0,1
    step(1'b0, 2'b01, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    step(1'b0, 2'b01, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    step(1'b0, 2'b01, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    step(1'b0, 2'b01, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    // load 1010 then shift left with din_l = 1
    step(1'b0, 2'b11, 1'b0, 1'b0, 4'b1010, 1'b0, 4'h0);
    step(1'b0, 2'b10, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0);
    // burst of 3 right shifts while mode toggles to LOAD
    step(1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    step(1'b0, 2'b01, 1'b1, 1'b0, 4'h0, 1'b1, 4'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 1'b1, 1'b0, 4'b1111, 1'b1, 4'd3);
    step(1'b0, 2'b11, 1'b1, 1'b0, 4'b1111, 1'b1, 4'd3);
    step(1'b0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    // abort: reset on the second busy cycle
    step(1'b0, 2'b01, 1'b1, 1'b0, 4'h0, 1'b1, 4'd3);
    step(1'b0, 2'b01, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    step(1'b1, 2'b01, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    // ignored starts: zero count, and LOAD mode
    step(1'b0, 2'b01, 1'b1, 1'b0, 4'h0, 1'b1, 4'd0);
    step(1'b0, 2'b11, 1'b0, 1'b0, 4'b0110, 1'b1, 4'd5);
    step(1'b0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    // long left burst (count > DEPTH) flushing with ones
    step(1'b0, 2'b10, 1'b0, 1'b1, 4'h0, 1'b1, 4'd15);
    for (int i = 0; i < 17; i++) step(1'b0, 2'b11, 1'b0, 1'b1, 4'h0, 1'b1, 4'd2);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
